// File: rtl/perm_delay_stage.sv
// Delay stage ahead of a 2x2 permutation switch: lane 0 is delayed DEPTH
// cycles more than lane 1, and ctrl flips between pass and cross every DEPTH output beats.
module perm_delay_stage #(
  parameter int DATA_WIDTH = 28,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] inData_0,
  input  logic [DATA_WIDTH-1:0] inData_1,
  input  logic                  inValid,
  input  logic                  inSync,
  output logic [DATA_WIDTH-1:0] outData_0,
  output logic [DATA_WIDTH-1:0] outData_1,
  output logic                  outValid,
  output logic                  ctrl
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] lane0_q [DEPTH+1];
  logic [DATA_WIDTH-1:0] lane1_q;
  logic [DEPTH:0]        valid_q;
  logic [DEPTH-1:0]      sync_q;
  logic [CW-1:0]         cnt_q, cnt_d, phase;
  logic                  ctrl_q, ctrl_d;

  // Sync only needs DEPTH stages: its last stage feeds the phase logic that
  // registers ctrl on the same edge the beat reaches the output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= DEPTH; i++) lane0_q[i] <= '0;
      lane1_q <= '0;
      valid_q <= '0;
      sync_q  <= '0;
      cnt_q   <= '0;
      ctrl_q  <= 1'b0;
    end else begin
      lane0_q[0] <= inData_0;
      for (int i = 1; i <= DEPTH; i++) lane0_q[i] <= lane0_q[i-1];
      lane1_q <= inData_1;
      valid_q <= {valid_q[DEPTH-1:0], inValid};
      sync_q  <= (sync_q << 1) | DEPTH'(inSync & inValid);
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Phase is decided for the beat about to enter the output stage; idle
  // cycles leave both the counter and ctrl untouched.
  always_comb begin
    cnt_d  = cnt_q;
    ctrl_d = ctrl_q;
    phase  = cnt_q;
    if (valid_q[DEPTH-1]) begin
      phase  = sync_q[DEPTH-1] ? '0 : cnt_q;
      ctrl_d = phase[CW-1];
      cnt_d  = sync_q[DEPTH-1] ? CW'(1) : cnt_q + 1'b1;
    end
  end

  assign outData_0 = lane0_q[DEPTH];
  assign outData_1 = lane1_q;
  assign outValid  = valid_q[DEPTH];
  assign ctrl      = ctrl_q;

endmodule
